collect_2x1_simple_seq: RTL and testbench

//  2-to-1 collector: merges two upstream branches (high/low) onto one downstream bus; inverse of the 1x2 distributor.

---
 rtl/collect_2x1_simple_seq_pkg.sv | 8 +
 rtl/collect_2x1_simple_seq_if.sv | 22 ++
 rtl/collect_2x1_simple_seq_out_reg.sv | 24 ++
 rtl/collect_2x1_simple_seq.sv | 84 ++++++++
 tb/tb_collect_2x1_simple_seq.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/collect_2x1_simple_seq_pkg.sv
// collect_2x1_simple_seq_pkg: command encodings and FSM states shared by the 2x1 collector
package collect_2x1_simple_seq_pkg;
    localparam logic [1:0] CMD_NA   = 2'b00;
    localparam logic [1:0] CMD_LOW  = 2'b01;
    localparam logic [1:0] CMD_HIGH = 2'b10;
    localparam logic [1:0] CMD_BOTH = 2'b11;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD_HIGH = 1'b1} state_t;
endpackage

// File: rtl/collect_2x1_simple_seq_if.sv
// collect_2x1_simple_seq_if: two upstream branches plus one downstream valid/ready bus
interface collect_2x1_simple_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COMMMAND_WIDTH = 2
);
    logic [1:0]                i_valid;
    logic [2*DATA_WIDTH-1:0]   i_data_bus;
    logic [1:0]                o_ready;
    logic                      o_valid;
    logic [DATA_WIDTH-1:0]     o_data_bus;
    logic                      i_ready;
    logic                      i_en;
    logic [COMMMAND_WIDTH-1:0] i_cmd;
    modport slave (
        input  i_valid, i_data_bus, i_ready, i_en, i_cmd,
        output o_ready, o_valid, o_data_bus
    );
    modport master (
        output i_valid, i_data_bus, i_ready, i_en, i_cmd,
        input  o_ready, o_valid, o_data_bus
    );
endinterface

// File: rtl/collect_2x1_simple_seq_out_reg.sv
// collect_out_reg: one-entry valid/data output register with load/drain and slot_free
module collect_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  slot_free
);
    assign slot_free = ~valid | ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (load) data <= load_data;
            valid <= load | (valid & ~ready);
        end
    end
endmodule

// File: rtl/collect_2x1_simple_seq.sv
// collect_2x1_simple_seq: 2-to-1 valid/ready collector; COLLECT_2X1_REDUCE_EN sums a cmd-11 pair into one beat
module collect_2x1_simple_seq
    import collect_2x1_simple_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    collect_2x1_simple_seq_if.slave bus
);
    logic [DATA_WIDTH-1:0] low, high, pair_data, load_data, out_data;
    logic [1:0] rdy;
    logic load, pair, out_load, slot_free;
    assign low  = bus.i_data_bus[DATA_WIDTH-1:0];
    assign high = bus.i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef COLLECT_2X1_REDUCE_EN
    assign pair_data = low + high;
`else
    assign pair_data = low;
`endif
    // IDLE acceptance decode; the serial build overrides it while a high beat is held
    always_comb begin
        rdy       = 2'b00;
        load      = 1'b0;
        load_data = low;
        pair      = 1'b0;
        if (rst_n && bus.i_en && slot_free) begin
            if (bus.i_cmd == CMD_LOW) begin
                rdy  = 2'b01;
                load = bus.i_valid[0];
            end else if (bus.i_cmd == CMD_HIGH) begin
                rdy       = 2'b10;
                load      = bus.i_valid[1];
                load_data = high;
            end else if (bus.i_cmd == CMD_BOTH) begin
                rdy       = bus.i_valid;
                load      = |bus.i_valid;
                pair      = &bus.i_valid;
                load_data = pair ? pair_data : (bus.i_valid[1] ? high : low);
            end
        end
    end
`ifdef COLLECT_2X1_REDUCE_EN
    assign bus.o_ready = rdy;
    assign out_load    = load;
    assign out_data    = load_data;
`else
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] hold;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hold  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && pair) hold <= high;
        end
    end
    always_comb begin
        state_nx    = state;
        bus.o_ready = rdy;
        out_load    = load;
        out_data    = load_data;
        if (state == ST_HOLD_HIGH) begin
            bus.o_ready = 2'b00;
            out_load    = slot_free;
            out_data    = hold;
            state_nx    = slot_free ? ST_IDLE : ST_HOLD_HIGH;
        end else if (pair) begin
            state_nx = ST_HOLD_HIGH;
        end
    end
`endif
    collect_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (out_load),
        .load_data(out_data),
        .ready    (bus.i_ready),
        .valid    (bus.o_valid),
        .data     (bus.o_data_bus),
        .slot_free(slot_free)
    );
endmodule

// File: tb/tb_collect_2x1_simple_seq.sv
// tb_collect_2x1_simple_seq: directed vectors with a queue scoreboard checked by a drain monitor
module tb_collect_2x1_simple_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;

    collect_2x1_simple_seq_if #(.DATA_WIDTH(32)) bus ();

    collect_2x1_simple_seq #(.DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] cmd, input logic [1:0] v, input logic [31:0] hi,
                        input logic [31:0] lo, input logic rdy);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.i_cmd      = cmd;
        bus.i_valid    = v;
        bus.i_data_bus = {hi, lo};
        bus.i_ready    = rdy;
        @(negedge clk);
    endtask

    // scoreboard monitor: every drained beat must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", bus.o_data_bus);
            end else begin
                got = exp_q.pop_front();
                chk("drain_data", bus.o_data_bus, got);
            end
        end
    end

    initial begin
        bus.i_en       = 1'b1;
        bus.i_cmd      = 2'b11;
        bus.i_valid    = 2'b11;
        bus.i_data_bus = {32'hBBBBBBBB, 32'hAAAAAAAA};
        bus.i_ready    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("reset_o_data", bus.o_data_bus, 32'd0);
        chk("reset_o_ready", {30'd0, bus.o_ready}, 32'd0);
        bus.i_valid = 2'b00;
        rst_n = 1'b1;

        step(2'b01, 2'b01, 32'h0, 32'hAAAAAAAA, 1'b1);
        chk("low_o_ready", {30'd0, bus.o_ready}, 32'd1);
        exp_q.push_back(32'hAAAAAAAA);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("low_o_valid", {31'd0, bus.o_valid}, 32'd1);
        chk("low_o_data", bus.o_data_bus, 32'hAAAAAAAA);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("drain_o_valid", {31'd0, bus.o_valid}, 32'd0);

`ifdef COLLECT_2X1_REDUCE_EN
        step(2'b11, 2'b11, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        chk("reduce_o_ready0", {30'd0, bus.o_ready}, 32'd3);
        exp_q.push_back(32'h00000001);
        step(2'b11, 2'b11, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        chk("reduce_o_ready1", {30'd0, bus.o_ready}, 32'd3);
        chk("reduce_o_data", bus.o_data_bus, 32'h00000001);
        exp_q.push_back(32'h00000001);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
`else
        step(2'b11, 2'b11, 32'hBBBBBBBB, 32'hAAAAAAAA, 1'b1);
        chk("pair_o_ready", {30'd0, bus.o_ready}, 32'd3);
        exp_q.push_back(32'hAAAAAAAA);
        exp_q.push_back(32'hBBBBBBBB);
        step(2'b11, 2'b11, 32'hCCCCCCCC, 32'hCCCCCCCC, 1'b1);
        chk("hold_o_ready", {30'd0, bus.o_ready}, 32'd0);
        chk("pair_first", bus.o_data_bus, 32'hAAAAAAAA);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("pair_second", bus.o_data_bus, 32'hBBBBBBBB);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("pair_done", {31'd0, bus.o_valid}, 32'd0);

        step(2'b11, 2'b11, 32'h22222222, 32'h11111111, 1'b1);
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 2'b11, 32'h0, 32'h0, 1'b0);
            chk("bp_o_data", bus.o_data_bus, 32'h11111111);
            chk("bp_o_ready", {30'd0, bus.o_ready}, 32'd0);
        end
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("bp_release_high", bus.o_data_bus, 32'h22222222);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);

        step(2'b11, 2'b11, 32'hDEADBEEF, 32'h0BADF00D, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.i_valid = 2'b00;
        @(negedge clk);
        chk("rst_mid_o_ready", {30'd0, bus.o_ready}, 32'd0);
        step(2'b01, 2'b01, 32'h0, 32'h12345678, 1'b1);
        chk("post_rst_o_ready", {30'd0, bus.o_ready}, 32'd1);
        exp_q.push_back(32'h12345678);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("post_rst_data", bus.o_data_bus, 32'h12345678);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
`endif

        for (int i = 0; i < 3; i++) begin
            step(2'b10, 2'b10, 32'h30000000 + i, 32'h0, 1'b1);
            chk("b2b_o_ready", {30'd0, bus.o_ready}, 32'd2);
            if (i > 0) chk("b2b_no_bubble", {31'd0, bus.o_valid}, 32'd1);
            exp_q.push_back(32'h30000000 + i);
        end
        step(2'b11, 2'b10, 32'h44444444, 32'h55555555, 1'b1);
        chk("both_hi_o_ready", {30'd0, bus.o_ready}, 32'd2);
        exp_q.push_back(32'h44444444);
        step(2'b11, 2'b01, 32'h66666666, 32'h77777777, 1'b1);
        chk("both_lo_o_ready", {30'd0, bus.o_ready}, 32'd1);
        exp_q.push_back(32'h77777777);
        step(2'b00, 2'b11, 32'h88888888, 32'h99999999, 1'b1);
        chk("na_o_ready", {30'd0, bus.o_ready}, 32'd0);
        bus.i_en = 1'b0;
        step(2'b01, 2'b01, 32'h0, 32'hEEEEEEEE, 1'b1);
        chk("dis_o_ready", {30'd0, bus.o_ready}, 32'd0);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        bus.i_en = 1'b1;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        step(2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        chk("final_idle", {31'd0, bus.o_valid}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
